// File: rtl/chunked_seq_adder_pkg.sv
// rtl/chunked_seq_adder_pkg.sv - shared types, defaults and sizing helpers for the chunked adder
package chunked_seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter to keep the port legal.
    function automatic int calc_cnt_w(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunked_seq_adder_if.sv
// rtl/chunked_seq_adder_if.sv - operand/result handshake bundle for the chunked adder
interface chunked_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/chunked_seq_adder_chunk_adder.sv
// rtl/chunked_seq_adder_chunk_adder.sv - combinational CHUNK-bit ripple-carry slice adder
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    logic [CHUNK:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign co = w_c[CHUNK];
endmodule

// File: rtl/chunked_seq_adder.sv
// rtl/chunked_seq_adder.sv - multi-cycle add/sub that ripples carry across CHUNK-bit slices
module chunked_seq_adder
    import chunked_seq_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input logic                i_clk,
    input logic                i_rst_n,
    chunked_seq_adder_if.slave bus
);
    localparam int                NCHUNK   = calc_nchunk(WIDTH, CHUNK);
    localparam int                CNT_W    = calc_cnt_w(WIDTH, CHUNK);
    localparam int                MSB      = WIDTH - 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NCHUNK - 1);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic [31:0]        w_base;
    logic [CHUNK-1:0]   w_s;
    logic               w_co;
    logic               w_last;

    assign w_base = 32'(r_cnt) * 32'(CHUNK);
    assign w_last = (r_cnt == LAST_CNT);

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .x  (r_a[w_base +: CHUNK]),
        .y  (r_b[w_base +: CHUNK]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_next = RUN;
            RUN:     if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is folded into the operand latch: b is inverted once and the +1 rides in as carry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_a     <= bus.a;
                    r_b     <= bus.sub ? ~bus.b : bus.b;
                    r_carry <= bus.sub | bus.cin;
                    r_cnt   <= '0;
                end
                RUN: begin
                    r_sum[w_base +: CHUNK] <= w_s;
                    r_carry                <= w_co;
                    r_cnt                  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout <= w_co;
                        r_ovf  <= (r_a[MSB] == r_b[MSB]) && (w_s[CHUNK-1] != r_a[MSB]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule
